// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared sizing constants and the address-hazard predicate for the RAM port arbiter
package mem_pkg;

  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 9;
  localparam int NCORE          = 4;
  localparam int CONFLICT_CNT_W = 16;

  typedef logic [1:0] core_idx_t;

  // Two accesses collide only when the full addresses match and at least one is a store.
  function automatic logic hazard(
    input logic [ADDR_W-1:0] addr_a,
    input logic [ADDR_W-1:0] addr_b,
    input logic              we_a,
    input logic              we_b
  );
    return (addr_a == addr_b) && (we_a || we_b);
  endfunction

endpackage

// File: rtl/conflict_grant4.sv
// rtl/conflict_grant4.sv - combinational grant walk over four cores starting at ptr
module conflict_grant4
  import mem_pkg::*;
(
  input  logic [NCORE-1:0]        req,
  input  logic [NCORE-1:0]        we,
  input  logic [NCORE*ADDR_W-1:0] addr,
  input  core_idx_t               ptr,
  output logic [NCORE-1:0]        gnt
);

  logic [NCORE-1:0] gnt_c;
  core_idx_t        idx;
  logic             clash;

  always_comb begin
    gnt_c = '0;
    idx   = '0;
    clash = 1'b0;
    for (int k = 0; k < NCORE; k++) begin
      idx   = ptr + core_idx_t'(k);
      clash = 1'b0;
      for (int j = 0; j < NCORE; j++) begin
        if (gnt_c[j] && hazard(addr[idx*ADDR_W +: ADDR_W], addr[j*ADDR_W +: ADDR_W],
                               we[idx], we[j])) begin
          clash = 1'b1;
        end
      end
      if (req[idx] && !clash) begin
        gnt_c[idx] = 1'b1;
      end
    end
  end

  assign gnt = gnt_c;

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - quad-port RAM arbiter with hazard stalls and saturating conflict count
// ARB_ROUND_ROBIN_EN selects rotating priority; undefined gives fixed core0-first priority.
module ram_port_arbiter
  import mem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NCORE-1:0]              core_req,
  input  logic [NCORE-1:0]              core_we,
  input  logic [NCORE*ADDR_W-1:0]       core_addr,
  input  logic [NCORE*DATA_W-1:0]       core_wdata,
  output logic [NCORE-1:0]              core_gnt,
  output logic [NCORE-1:0]              core_rvalid,
  output logic [NCORE*DATA_W-1:0]       core_rdata,
  output logic [NCORE-1:0]              ram_we,
  output logic [NCORE-1:0]              ram_re,
  output logic [NCORE*ADDR_W-1:0]       ram_addr,
  output logic [NCORE*DATA_W-1:0]       ram_din,
  input  logic [NCORE*DATA_W-1:0]       ram_dout,
  output logic [CONFLICT_CNT_W-1:0]     conflict_cnt
);

  core_idx_t                 ptr_q, ptr_d;
  logic [NCORE-1:0]          rvalid_q, rvalid_d;
  logic [CONFLICT_CNT_W-1:0] cnt_q, cnt_d;
  logic [NCORE-1:0]          gnt_raw;
  logic [NCORE-1:0]          gnt;
  logic [NCORE-1:0]          denied;

  conflict_grant4 u_grant (
    .req  (core_req),
    .we   (core_we),
    .addr (core_addr),
    .ptr  (ptr_q),
    .gnt  (gnt_raw)
  );

`ifdef ARB_ROUND_ROBIN_EN
  core_idx_t idx;
  core_idx_t first_denied;
`endif

  always_comb begin
    gnt      = rst_n ? gnt_raw : '0;
    denied   = core_req & ~gnt_raw;
    rvalid_d = gnt & ~core_we;
    cnt_d    = cnt_q;
    if ((|denied) && (cnt_q != {CONFLICT_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef ARB_ROUND_ROBIN_EN
    // Scanning the order backwards leaves the earliest denied core in first_denied.
    idx          = '0;
    first_denied = ptr_q;
    for (int k = NCORE - 1; k >= 0; k--) begin
      idx = ptr_q + core_idx_t'(k);
      if (denied[idx]) begin
        first_denied = idx;
      end
    end
    ptr_d = (|denied) ? first_denied : ptr_q;
`else
    ptr_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign core_gnt     = gnt;
  assign ram_we       = gnt & core_we;
  assign ram_re       = gnt & ~core_we;
  assign ram_addr     = core_addr;
  assign ram_din      = core_wdata;
  assign core_rdata   = ram_dout;
  assign core_rvalid  = rvalid_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a behavioural quad-port RAM
module tb_ram_port_arbiter;
  import mem_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NCORE-1:0]          core_req, core_we, core_gnt, core_rvalid, ram_we, ram_re;
  logic [NCORE*ADDR_W-1:0]   core_addr, ram_addr;
  logic [NCORE*DATA_W-1:0]   core_wdata, core_rdata, ram_din, ram_dout;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_gnt     (core_gnt),
    .core_rvalid  (core_rvalid),
    .core_rdata   (core_rdata),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .conflict_cnt (conflict_cnt)
  );

  logic [DATA_W-1:0] mem [32];
  logic              preload;
  int                n_checks = 0;
  int                n_errs   = 0;
  logic [DATA_W-1:0] exp_q [NCORE][$];
  int                gcnt [NCORE];
  int                wt   [NCORE];
  int                wmax [NCORE];
  logic [NCORE-1:0]  g4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM: one-cycle read latency, output held until the next read on that port
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 32; a++) mem[a] <= 16'hA000 + 16'(a);
    end else begin
      for (int i = 0; i < NCORE; i++) begin
        if (ram_we[i]) mem[ram_addr[i*ADDR_W +: 5]] <= ram_din[i*DATA_W +: DATA_W];
        if (ram_re[i]) ram_dout[i*DATA_W +: DATA_W] <= mem[ram_addr[i*ADDR_W +: 5]];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NCORE; i++) begin
        if (core_rvalid[i]) begin
          if (exp_q[i].size() == 0) check($sformatf("rvalid_unexpected_core%0d", i), 32'd1, 32'd0);
          else check($sformatf("rdata_core%0d", i), 32'(core_rdata[i*DATA_W +: DATA_W]),
                     32'(exp_q[i].pop_front()));
        end
      end
    end
  end

  task automatic set_core(input int i, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    core_req[i] = 1'b1;
    core_we[i]  = w;
    core_addr[i*ADDR_W +: ADDR_W]  = a;
    core_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic step(output logic [NCORE-1:0] g);
    @(negedge clk);
    g = core_gnt;
    @(posedge clk);
    #1;
    core_req = core_req & ~g;
  endtask

  task automatic expect_gnt(input string tag, input logic [NCORE-1:0] exp);
    logic [NCORE-1:0] g;
    step(g);
    check(tag, 32'(g), 32'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    set_core(1, 1'b0, 9'd1, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_gnt", 32'(core_gnt), 32'd0);
    check("rst_rvalid", 32'(core_rvalid), 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    check("rst_ram_en", 32'(ram_we | ram_re), 32'd0);
    core_req = '0; preload = 1'b0; rst_n = 1'b1;
    idle(1);

    // distinct loads all granted together
    for (int i = 0; i < NCORE; i++) begin
      set_core(i, 1'b0, 9'(i + 1), 16'h0);
      exp_q[i].push_back(16'hA000 + 16'(i + 1));
    end
    expect_gnt("t1_gnt", 4'b1111);
    idle(2);
    check("t1_cnt", 32'(conflict_cnt), 32'd0);

    // read/read same address and full-address compare (35 aliases word 3)
    set_core(0, 1'b0, 9'd2, 16'h0);  exp_q[0].push_back(16'hA002);
    set_core(1, 1'b0, 9'd2, 16'h0);  exp_q[1].push_back(16'hA002);
    set_core(2, 1'b1, 9'd3, 16'h7777);
    set_core(3, 1'b0, 9'd35, 16'h0); exp_q[3].push_back(16'hA003);
    expect_gnt("alias_gnt", 4'b1111);
    idle(2);
    check("alias_cnt", 32'(conflict_cnt), 32'd0);

    // store/store hazard from ptr=0
    set_core(0, 1'b1, 9'd5, 16'hAAAA);
    set_core(2, 1'b1, 9'd5, 16'h5555);
    expect_gnt("t2_c0", 4'b0001);
    expect_gnt("t2_c1", 4'b0100);
    check("t2_cnt", 32'(conflict_cnt), 32'd1);
    set_core(1, 1'b0, 9'd5, 16'h0); exp_q[1].push_back(16'h5555);
    expect_gnt("t2_rd", 4'b0010);
    idle(2);

    // cores 2,3 collide so that core3 becomes first in order
    set_core(2, 1'b1, 9'd10, 16'h0001);
    set_core(3, 1'b1, 9'd10, 16'h0002);
    expect_gnt("setup_c0", 4'b0100);
    expect_gnt("setup_c1", 4'b1000);

    // load/store hazard
    set_core(1, 1'b0, 9'd7, 16'h0);
    set_core(3, 1'b1, 9'd7, 16'h1234);
`ifdef ARB_ROUND_ROBIN_EN
    exp_q[1].push_back(16'h1234);
    expect_gnt("t3_c0", 4'b1000);
    expect_gnt("t3_c1", 4'b0010);
`else
    exp_q[1].push_back(16'hA007);
    expect_gnt("t3_c0", 4'b0010);
    expect_gnt("t3_c1", 4'b1000);
`endif
    idle(2);
    check("t3_cnt", 32'(conflict_cnt), 32'd3);

    // all four store one address for 8 cycles
    for (int i = 0; i < NCORE; i++) begin
      gcnt[i] = 0; wt[i] = 0; wmax[i] = 0;
      set_core(i, 1'b1, 9'd9, 16'h9000 + 16'(i));
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g4 = core_gnt;
      check("t4_onehot", 32'($countones(g4)), 32'd1);
      for (int i = 0; i < NCORE; i++) begin
        if (g4[i]) begin
          gcnt[i]++; wt[i] = 0;
        end else begin
          wt[i]++;
          if (wt[i] > wmax[i]) wmax[i] = wt[i];
        end
      end
      @(posedge clk); #1;
    end
    core_req = '0;
    for (int i = 0; i < NCORE; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check($sformatf("t4_grants_core%0d", i), 32'(gcnt[i]), 32'd2);
      check($sformatf("t4_wait_le3_core%0d", i), 32'(wmax[i] <= 3), 32'd1);
`else
      check($sformatf("t4_grants_core%0d", i), 32'(gcnt[i]), (i == 0) ? 32'd8 : 32'd0);
`endif
    end
    check("t4_cnt", 32'(conflict_cnt), 32'd11);

    // saturation of the conflict counter
    set_core(2, 1'b1, 9'd20, 16'h0001);
    set_core(3, 1'b1, 9'd20, 16'h0002);
    repeat (65523) @(posedge clk);
    #1;
    check("t5_cnt_fffe", 32'(conflict_cnt), 32'h0000FFFE);
    @(posedge clk); #1;
    check("t5_cnt_ffff", 32'(conflict_cnt), 32'h0000FFFF);
    repeat (20) @(posedge clk);
    #1;
    check("t5_cnt_hold", 32'(conflict_cnt), 32'h0000FFFF);
    core_req = '0;
    idle(1);

    // reset while a load is outstanding
    set_core(0, 1'b0, 9'd1, 16'h0);
    expect_gnt("t6_gnt", 4'b0001);
    check("t6_rvalid_pre", 32'(core_rvalid), 32'd1);
    set_core(0, 1'b1, 9'd12, 16'h00C0);
    set_core(3, 1'b1, 9'd12, 16'h00C3);
    rst_n = 1'b0;
    #1;
    check("t6_rvalid", 32'(core_rvalid), 32'd0);
    check("t6_gnt_rst", 32'(core_gnt), 32'd0);
    check("t6_ram_en", 32'(ram_we | ram_re), 32'd0);
    check("t6_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_gnt("t6_ptr0", 4'b0001);
    expect_gnt("t6_next", 4'b1000);
    idle(2);
    check("t6_cnt_after", 32'(conflict_cnt), 32'd1);

    for (int i = 0; i < NCORE; i++)
      check($sformatf("sb_drained_core%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
